// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-requester bus acknowledge arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        OWN1   = 2'd2,
        OWN2   = 2'd3
    } arb_state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_OWN1 = 2'b01;
    localparam logic [1:0] SEL_OWN2 = 2'b10;

    localparam int unsigned MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/bus_arb_hold_timer.sv
// Saturating hold counter for the current bus owner; expire_c flags that the
// owner has used its MAX_HOLD-cycle share of the bus.
module bus_arb_hold_timer
    import bus_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] count;

    // Counts owned cycles; parks at MAX_HOLD so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(MAX_HOLD))) begin
            count <= count + CNT_W'(1);
        end
    end

    // >= keeps preemption live once the count has saturated, so a requester
    // arriving late in a long tenure is not locked out.
    assign expire_c = (count >= CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/bus_ack_arbiter.sv
// Two-requester round-robin bus arbiter with a dead SWITCH cycle on every
// hand-over. Define BUS_ACK_ARBITER_ASSERT_EN to compile embedded assertions.
module bus_ack_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req1,
    input  logic       req2,
    output logic       ack1,
    output logic       ack2,
    output logic [1:0] bus_select,
    output logic       bus_switch
);

    arb_state_t state, state_d;
    logic [1:0] target, target_d;
    logic [1:0] last_owner, last_owner_d;
    logic       ack1_d, ack2_d, bus_switch_d;
    logic [1:0] bus_select_d;
    logic       owning_c;
    logic       hold_expire_c;

    assign owning_c = (state == OWN1) || (state == OWN2);

    bus_arb_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!owning_c),
        .enable   (owning_c),
        .expire_c (hold_expire_c)
    );

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= SEL_NONE;
            last_owner <= SEL_OWN2;
            ack1       <= 1'b0;
            ack2       <= 1'b0;
            bus_select <= SEL_NONE;
            bus_switch <= 1'b0;
        end else begin
            state      <= state_d;
            target     <= target_d;
            last_owner <= last_owner_d;
            ack1       <= ack1_d;
            ack2       <= ack2_d;
            bus_select <= bus_select_d;
            bus_switch <= bus_switch_d;
        end
    end

    // Next state plus outputs decoded from it, so outputs track state exactly.
    always_comb begin
        state_d      = state;
        target_d     = target;
        last_owner_d = last_owner;

        case (state)
            IDLE: begin
                if (req1 && req2) begin
                    state_d  = SWITCH;
                    target_d = (last_owner == SEL_OWN1) ? SEL_OWN2 : SEL_OWN1;
                end else if (req1) begin
                    state_d  = SWITCH;
                    target_d = SEL_OWN1;
                end else if (req2) begin
                    state_d  = SWITCH;
                    target_d = SEL_OWN2;
                end
            end
            SWITCH: begin
                if ((target == SEL_OWN1) && req1) begin
                    state_d      = OWN1;
                    last_owner_d = SEL_OWN1;
                end else if ((target == SEL_OWN2) && req2) begin
                    state_d      = OWN2;
                    last_owner_d = SEL_OWN2;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (!req1) begin
                    if (req2) begin
                        state_d  = SWITCH;
                        target_d = SEL_OWN2;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (req2 && hold_expire_c) begin
                    state_d  = SWITCH;
                    target_d = SEL_OWN2;
                end
            end
            OWN2: begin
                if (!req2) begin
                    if (req1) begin
                        state_d  = SWITCH;
                        target_d = SEL_OWN1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (req1 && hold_expire_c) begin
                    state_d  = SWITCH;
                    target_d = SEL_OWN1;
                end
            end
            default: state_d = IDLE;
        endcase

        ack1_d       = (state_d == OWN1);
        ack2_d       = (state_d == OWN2);
        bus_switch_d = (state_d == SWITCH);
        case (state_d)
            OWN1:    bus_select_d = SEL_OWN1;
            OWN2:    bus_select_d = SEL_OWN2;
            default: bus_select_d = SEL_NONE;
        endcase
    end

`ifdef BUS_ACK_ARBITER_ASSERT_EN
    default clocking cb_arb @(posedge clk);
    endclocking

    a_ack1_state:  assert property (disable iff (!rst_n) ack1 == (state == OWN1));
    a_ack2_state:  assert property (disable iff (!rst_n) ack2 == (state == OWN2));
    a_sw_state:    assert property (disable iff (!rst_n) bus_switch == (state == SWITCH));
    a_sel_own1:    assert property (disable iff (!rst_n) (state == OWN1) |-> (bus_select == SEL_OWN1));
    a_sel_own2:    assert property (disable iff (!rst_n) (state == OWN2) |-> (bus_select == SEL_OWN2));
    a_sel_none:    assert property (disable iff (!rst_n)
                                    ((state == IDLE) || (state == SWITCH)) |-> (bus_select == SEL_NONE));
    a_sel_legal:   assert property (disable iff (!rst_n) bus_select != 2'b11);
    a_ack_mutex:   assert property (disable iff (!rst_n) !(ack1 && ack2));
    a_sw_pulse:    assert property (disable iff (!rst_n) bus_switch |=> !bus_switch);
    a_hand_1to2:   assert property (disable iff (!rst_n) ack1 |=> !ack2);
    a_hand_2to1:   assert property (disable iff (!rst_n) ack2 |=> !ack1);
`endif

endmodule

// File: tb/tb_bus_ack_arbiter.sv
// Directed and constrained-random bench for bus_ack_arbiter (MAX_HOLD = 4).
module tb_bus_ack_arbiter;

    localparam int unsigned HOLD = 4;

    // Observation word: {ack1, ack2, bus_select[1:0], bus_switch}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_SW   = 5'b00001;
    localparam logic [4:0] O_OWN1 = 5'b10010;
    localparam logic [4:0] O_OWN2 = 5'b01100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req1;
    logic       req2;
    logic       ack1;
    logic       ack2;
    logic [1:0] bus_select;
    logic       bus_switch;
    logic [4:0] obs;

    int vec = 0;
    int err = 0;

    bus_ack_arbiter #(
        .MAX_HOLD (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req1       (req1),
        .req2       (req2),
        .ack1       (ack1),
        .ack2       (ack2),
        .bus_select (bus_select),
        .bus_switch (bus_switch)
    );

    always #5 clk = ~clk;

    assign obs = {ack1, ack2, bus_select, bus_switch};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req1  = 1'b0;
        req2  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req1  = 1'b1;
        req2  = 1'b1;
        repeat (3) tick();
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL reset_held: obs=%b exp=%b", obs, O_IDLE); end
        req1 = 1'b0;
        req2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL reset_release: obs=%b exp=%b", obs, O_IDLE); end
    endtask

    task automatic test_single_grant();
        do_reset();
        req1 = 1'b1;
        tick();
        vec++; if (obs !== O_SW)   begin err++; $display("FAIL single_switch: obs=%b exp=%b", obs, O_SW); end
        tick();
        vec++; if (obs !== O_OWN1) begin err++; $display("FAIL single_ack: obs=%b exp=%b", obs, O_OWN1); end
        tick();
        vec++; if (obs !== O_OWN1) begin err++; $display("FAIL single_hold: obs=%b exp=%b", obs, O_OWN1); end
        req1 = 1'b0;
        tick();
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL single_release: obs=%b exp=%b", obs, O_IDLE); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req1 = 1'b1;
        req2 = 1'b1;
        tick();
        vec++; if (obs !== O_SW)   begin err++; $display("FAIL rr_switch0: obs=%b exp=%b", obs, O_SW); end
        tick();
        vec++; if (obs !== O_OWN1) begin err++; $display("FAIL rr_first: obs=%b exp=%b", obs, O_OWN1); end
        tick();
        req1 = 1'b0;
        tick();
        vec++; if (obs !== O_SW)   begin err++; $display("FAIL rr_switch1: obs=%b exp=%b", obs, O_SW); end
        tick();
        vec++; if (obs !== O_OWN2) begin err++; $display("FAIL rr_second: obs=%b exp=%b", obs, O_OWN2); end
        req2 = 1'b0;
        tick();
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL rr_idle: obs=%b exp=%b", obs, O_IDLE); end
        // last owner is 2 -> tie goes to 1
        req1 = 1'b1;
        req2 = 1'b1;
        repeat (2) tick();
        vec++; if (obs !== O_OWN1) begin err++; $display("FAIL rr_tie_to1: obs=%b exp=%b", obs, O_OWN1); end
        req1 = 1'b0;
        req2 = 1'b0;
        tick();
        // last owner is 1 -> tie goes to 2
        req1 = 1'b1;
        req2 = 1'b1;
        repeat (2) tick();
        vec++; if (obs !== O_OWN2) begin err++; $display("FAIL rr_tie_to2: obs=%b exp=%b", obs, O_OWN2); end
        req1 = 1'b0;
        req2 = 1'b0;
        tick();
    endtask

    task automatic test_preempt();
        do_reset();
        req1 = 1'b1;
        repeat (2) tick();
        vec++; if (obs !== O_OWN1) begin err++; $display("FAIL pre_own1_entry: obs=%b exp=%b", obs, O_OWN1); end
        req2 = 1'b1;
        for (int i = 1; i < int'(HOLD); i++) begin
            tick();
            vec++; if (obs !== O_OWN1) begin err++; $display("FAIL pre_own1_c%0d: obs=%b exp=%b", i, obs, O_OWN1); end
        end
        tick();
        vec++; if (obs !== O_SW) begin err++; $display("FAIL pre_switch12: obs=%b exp=%b", obs, O_SW); end
        for (int i = 0; i < int'(HOLD); i++) begin
            tick();
            vec++; if (obs !== O_OWN2) begin err++; $display("FAIL pre_own2_c%0d: obs=%b exp=%b", i, obs, O_OWN2); end
        end
        tick();
        vec++; if (obs !== O_SW) begin err++; $display("FAIL pre_switch21: obs=%b exp=%b", obs, O_SW); end
        req1 = 1'b0;
        req2 = 1'b0;
        tick();
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL pre_cancel: obs=%b exp=%b", obs, O_IDLE); end
    endtask

    task automatic test_hold_forever();
        do_reset();
        req1 = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            vec++; if (obs !== O_OWN1) begin err++; $display("FAIL hold_own1_c%0d: obs=%b exp=%b", i, obs, O_OWN1); end
        end
        req2 = 1'b1;
        tick();
        vec++; if (obs !== O_SW)   begin err++; $display("FAIL hold_late_switch: obs=%b exp=%b", obs, O_SW); end
        tick();
        vec++; if (obs !== O_OWN2) begin err++; $display("FAIL hold_late_own2: obs=%b exp=%b", obs, O_OWN2); end
        req1 = 1'b0;
        req2 = 1'b0;
        tick();
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL hold_idle: obs=%b exp=%b", obs, O_IDLE); end
    endtask

    task automatic test_drop_and_rise();
        do_reset();
        req1 = 1'b1;
        repeat (2) tick();
        req1 = 1'b0;
        req2 = 1'b1;
        tick();
        vec++; if (obs !== O_SW)   begin err++; $display("FAIL swap_switch: obs=%b exp=%b", obs, O_SW); end
        tick();
        vec++; if (obs !== O_OWN2) begin err++; $display("FAIL swap_own2: obs=%b exp=%b", obs, O_OWN2); end
        req2 = 1'b0;
        tick();
    endtask

    task automatic test_cancel_pulse();
        do_reset();
        req2 = 1'b1;
        tick();
        vec++; if (obs !== O_SW)   begin err++; $display("FAIL cancel_switch: obs=%b exp=%b", obs, O_SW); end
        req2 = 1'b0;
        tick();
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL cancel_idle: obs=%b exp=%b", obs, O_IDLE); end
        tick();
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL cancel_no_ack: obs=%b exp=%b", obs, O_IDLE); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req2 = 1'b1;
        repeat (3) tick();
        vec++; if (obs !== O_OWN2) begin err++; $display("FAIL arst_pre_own2: obs=%b exp=%b", obs, O_OWN2); end
        #3;
        rst_n = 1'b0;
        #1;
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL arst_immediate: obs=%b exp=%b", obs, O_IDLE); end
        tick();
        vec++; if (obs !== O_IDLE) begin err++; $display("FAIL arst_no_pulse: obs=%b exp=%b", obs, O_IDLE); end
        req2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        req1 = 1'b1;
        req2 = 1'b1;
        tick();
        vec++; if (obs !== O_SW)   begin err++; $display("FAIL arst_switch: obs=%b exp=%b", obs, O_SW); end
        tick();
        vec++; if (obs !== O_OWN1) begin err++; $display("FAIL arst_rr_own1: obs=%b exp=%b", obs, O_OWN1); end
        req1 = 1'b0;
        req2 = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic       r1, r2;
        logic       p_ack1, p_ack2, p_sw;
        logic [1:0] exp_sel;
        int         w1, w2;
        do_reset();
        p_ack1 = 1'b0;
        p_ack2 = 1'b0;
        p_sw   = 1'b0;
        w1     = 0;
        w2     = 0;
        for (int c = 0; c < 3000; c++) begin
            // requests are held until acked, then dropped at random
            if (!req1)     req1 = ($urandom_range(2) == 0);
            else if (ack1) req1 = ($urandom_range(3) != 0);
            if (!req2)     req2 = ($urandom_range(2) == 0);
            else if (ack2) req2 = ($urandom_range(3) != 0);
            r1 = req1;
            r2 = req2;
            tick();
            exp_sel = ack1 ? 2'b01 : (ack2 ? 2'b10 : 2'b00);
            vec++; if (ack1 && ack2) begin err++; $display("FAIL rnd_mutex c%0d: ack1=%b ack2=%b exp not both", c, ack1, ack2); end
            vec++; if (bus_select !== exp_sel) begin err++; $display("FAIL rnd_sel c%0d: sel=%b exp=%b", c, bus_select, exp_sel); end
            vec++; if (((ack1 && !p_ack1) || (ack2 && !p_ack2)) && !p_sw) begin
                err++; $display("FAIL rnd_handover c%0d: grant without prior switch, prev_sw=%b exp=1", c, p_sw);
            end
            vec++; if (bus_switch && p_sw) begin err++; $display("FAIL rnd_sw_width c%0d: sw=%b prev=%b exp single pulse", c, bus_switch, p_sw); end
            w1 = (r1 && !ack1) ? w1 + 1 : 0;
            w2 = (r2 && !ack2) ? w2 + 1 : 0;
            vec++; if (w1 > int'(HOLD) + 2) begin err++; $display("FAIL rnd_starve1 c%0d: wait=%0d exp<=%0d", c, w1, HOLD + 2); end
            vec++; if (w2 > int'(HOLD) + 2) begin err++; $display("FAIL rnd_starve2 c%0d: wait=%0d exp<=%0d", c, w2, HOLD + 2); end
            p_ack1 = ack1;
            p_ack2 = ack2;
            p_sw   = bus_switch;
        end
        req1 = 1'b0;
        req2 = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req1  = 1'b0;
        req2  = 1'b0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_preempt();
        test_hold_forever();
        test_drop_and_rise();
        test_cancel_pulse();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
